// File: rtl/mul_add_pkg.sv
// Shared constants for the multiply-by-repeated-addition scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default datapath width, the FSM state encoding and a small
// helper that turns a requester index into a one-hot vector.
package mul_add_pkg;

    // Default operand / product / result width in bits.
    localparam int DEFAULT_W = 8;

    // FSM state encoding. Plain constants rather than an enum so the
    // encoding stays fixed for anything probing the state bits directly.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LDA  = 3'd1;
    localparam logic [2:0] ST_LDB  = 3'd2;
    localparam logic [2:0] ST_ACC  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef logic [2:0] state_t;

    // Requester index (0/1) to one-hot grant/done vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// Latency: 0 cycles (winner follows req/last_served combinationally).
// Backpressure: none; the caller decides when to sample the winner.
//
// Ports:
//   req[1:0]     - request vector
//   last_served  - index of the requester that completed most recently
//   winner       - index of the requester that should be served next
//                  (don't-care when req == 0; reported as 0)
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            // Contention: hand the turn to whoever was not served last.
            winner = ~last_served;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mul_add_scheduler.sv
// Arbitrates two multiply requesters onto an external repeated-addition datapath.
// Latency: B+4 cycles from the IDLE cycle that samples req to the done pulse.
// Backpressure: req is a level held until done; losers simply wait in IDLE.
//
// Ports:
//   clk, rst_n           - single clock, synchronous active-low reset
//   req[1:0]             - per-requester request level
//   a0/b0, a1/b1         - requester operands, stable while that gnt is high
//   gnt[1:0]             - registered one-hot grant, high from LDA to DONE
//   done[1:0]            - one-cycle completion pulse for the granted requester
//   result               - last product, valid from the done cycle onward
//   lda/ldb/clrp/ldp/decb- datapath control strobes
//   data_in              - operand bus into the datapath
//   eqz, prod            - datapath status: B register is zero, product register
module mul_add_scheduler
    import mul_add_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [W-1:0] result,
    output logic         lda,
    output logic         ldb,
    output logic         ldp,
    output logic         clrp,
    output logic         decb,
    output logic [W-1:0] data_in,
    input  logic         eqz,
    input  logic [W-1:0] prod
);

    state_t       state_q, state_d;
    logic         win_q, win_d;        // requester owning the current operation
    logic         last_q, last_d;      // requester that completed most recently
    logic [1:0]   gnt_q, gnt_d;
    logic [W-1:0] result_q, result_d;

    logic         arb_win;

    rr_arbiter2 u_arb (
        .req         (req),
        .last_served (last_q),
        .winner      (arb_win)
    );

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        result_d = result_q;

        lda      = 1'b0;
        ldb      = 1'b0;
        clrp     = 1'b0;
        ldp      = 1'b0;
        decb     = 1'b0;
        done     = 2'b00;
        data_in  = '0;
        result   = result_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d = 2'b00;
                if (|req) begin
                    // Winner is latched here; operands are then muxed from
                    // the latched index so a late req change cannot switch
                    // requesters mid-operation.
                    win_d   = arb_win;
                    gnt_d   = onehot2(arb_win);
                    state_d = ST_LDA;
                end
            end

            ST_LDA: begin
                lda     = 1'b1;
                data_in = win_q ? a1 : a0;
                state_d = ST_LDB;
            end

            ST_LDB: begin
                ldb     = 1'b1;
                clrp    = 1'b1;
                data_in = win_q ? b1 : b0;
                state_d = ST_ACC;
            end

            ST_ACC: begin
                // One add per remaining unit of B; eqz is live from the
                // datapath so the B=0 case falls straight through.
                if (!eqz) begin
                    ldp  = 1'b1;
                    decb = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // prod is stable here (no ldp), so expose it directly this
                // cycle and capture it for the cycles that follow.
                done     = onehot2(win_q);
                result   = prod;
                result_d = prod;
                last_d   = win_q;
                gnt_d    = 2'b00;
                state_d  = ST_IDLE;
            end

            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            win_q    <= 1'b0;
            last_q   <= 1'b1;   // requester 0 wins the first tie
            gnt_q    <= 2'b00;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            result_q <= result_d;
        end
    end

    assign gnt = gnt_q;

endmodule

// File: tb/tb_mul_add_scheduler.sv
// Self-checking bench for mul_add_scheduler with a behavioural datapath.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mul_add_scheduler;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   gnt, done;
    logic [W-1:0] result, data_in;
    logic         lda, ldb, ldp, clrp, decb;
    logic         eqz;
    logic [W-1:0] prod;

    int vectors = 0;
    int misc    = 0;

    always #5 clk = ~clk;

    mul_add_scheduler #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .done    (done),
        .result  (result),
        .lda     (lda),
        .ldb     (ldb),
        .ldp     (ldp),
        .clrp    (clrp),
        .decb    (decb),
        .data_in (data_in),
        .eqz     (eqz),
        .prod    (prod)
    );

    // External repeated-addition datapath.
    logic [W-1:0] dp_a = '0, dp_b = '0, dp_p = '0;
    always @(posedge clk) begin
        if (lda)  dp_a <= data_in;
        if (ldb)  dp_b <= data_in;
        if (decb) dp_b <= dp_b - 1'b1;
        if (clrp)     dp_p <= '0;
        else if (ldp) dp_p <= dp_p + dp_a;
    end
    assign eqz  = (dp_b == '0);
    assign prod = dp_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each operation is a timeline of offsets
    // t = 1 (load A), 2 (load B), 3..B+2 (adds), B+3 (zero seen), B+4 (done).
    bit           started = 0;
    bit           m_busy  = 0;
    int           m_t     = 0;
    logic         m_win   = 1'b0;
    logic         m_last  = 1'b1;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1;
            m_busy  = 0;
            m_t     = 0;
            m_last  = 1'b1;
            m_res   = '0;
        end else if (!m_busy) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_win = ~m_last;
                else              m_win = req[1];
                m_a    = m_win ? a1 : a0;
                m_b    = m_win ? b1 : b0;
                m_busy = 1;
                m_t    = 1;
            end
        end else if (m_t == int'(m_b) + 4) begin
            m_busy = 0;
            m_t    = 0;
            m_last = m_win;
            m_res  = W'(m_a * m_b);
        end else begin
            m_t++;
        end
    end

    int ldp_cnt  = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        logic [1:0]   e_gnt, e_done;
        logic [W-1:0] e_data, e_res, e_prod;
        bit           e_acc, e_done_t;
        if (ldp)           ldp_cnt++;
        if (done != 2'b00) done_cnt++;
        if (started) begin
            e_prod   = W'(m_a * m_b);
            e_acc    = m_busy && m_t >= 3 && m_t <= int'(m_b) + 2;
            e_done_t = m_busy && m_t == int'(m_b) + 4;
            e_gnt    = m_busy ? (m_win ? 2'b10 : 2'b01) : 2'b00;
            e_done   = e_done_t ? e_gnt : 2'b00;
            e_data   = (m_busy && m_t == 1) ? m_a : (m_busy && m_t == 2) ? m_b : '0;
            e_res    = e_done_t ? e_prod : m_res;
            check("gnt",     gnt,     e_gnt);
            check("done",    done,    e_done);
            check("result",  result,  e_res);
            check("data_in", data_in, e_data);
            check("lda",     lda,     m_busy && m_t == 1);
            check("ldb",     ldb,     m_busy && m_t == 2);
            check("clrp",    clrp,    m_busy && m_t == 2);
            check("ldp",     ldp,     e_acc);
            check("decb",    decb,    e_acc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the current IDLE sample until a done pulse.
    task automatic wait_done(input int budget, output logic [1:0] d, output int cyc);
        d   = 2'b00;
        cyc = 0;
        while (cyc < budget) begin
            tick();
            cyc++;
            if (done != 2'b00) begin
                d = done;
                return;
            end
        end
        vectors++;
        misc++;
        $display("FAIL done_timeout: no done within %0d cycles at %0t", budget, $time);
    endtask

    task automatic do_reset();
        req   = 2'b00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] d;
        int         c;
        int         snap;

        do_reset();
        check("rst_gnt",    gnt,     0);
        check("rst_done",   done,    0);
        check("rst_result", result,  0);
        check("rst_data",   data_in, 0);
        check("rst_strobe", {lda, ldb, ldp, clrp, decb}, 0);

        // 5 * 3
        a0 = 8'd5; b0 = 8'd3; snap = ldp_cnt;
        req = 2'b01;
        wait_done(20, d, c);
        check("t1_done", d, 2'b01);
        check("t1_lat",  c, 7);
        check("t1_res",  result, 15);
        check("t1_adds", ldp_cnt - snap, 3);
        req = 2'b00;
        tick(); tick();
        check("t1_hold", result, 15);

        // B = 0, request dropped mid-operation
        a1 = 8'd9; b1 = 8'd0; snap = ldp_cnt;
        req = 2'b10;
        tick();
        req = 2'b00;
        wait_done(20, d, c);
        check("t2_done", d, 2'b10);
        check("t2_lat",  c + 1, 4);
        check("t2_res",  result, 0);
        check("t2_adds", ldp_cnt - snap, 0);
        tick();

        // Simultaneous requests right after reset
        do_reset();
        a0 = 8'd2; b0 = 8'd2; a1 = 8'd4; b1 = 8'd1;
        req = 2'b11;
        wait_done(20, d, c);
        check("t3_first",  d, 2'b01);
        check("t3_res0",   result, 4);
        req = 2'b10;
        wait_done(20, d, c);
        check("t3_second", d, 2'b10);
        check("t3_res1",   result, 4);
        check("t3_gap",    c, 6);
        req = 2'b00;
        tick();

        // Wrap modulo 2^W
        a0 = 8'd20; b0 = 8'd20;
        req = 2'b01;
        wait_done(60, d, c);
        check("t4_done", d, 2'b01);
        check("t4_res",  result, 144);
        check("t4_lat",  c, 24);
        req = 2'b00;
        tick();

        // Reset during ACC aborts without done
        a0 = 8'd3; b0 = 8'd6;
        req = 2'b01;
        tick(); tick(); tick(); tick();
        check("t5_in_acc", ldp, 1);
        snap  = done_cnt;
        req   = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_gnt",    gnt,     0);
        check("t5_done",   done,    0);
        check("t5_data",   data_in, 0);
        check("t5_strobe", {lda, ldb, ldp, clrp, decb}, 0);
        check("t5_result", result,  0);
        tick(); tick(); tick();
        check("t5_nodone", done_cnt - snap, 0);
        req = 2'b01;
        wait_done(30, d, c);
        check("t5_redo",  d, 2'b01);
        check("t5_res",   result, 18);
        check("t5_lat",   c, 10);
        req = 2'b00;
        tick();

        // Fairness: req0 held, req1 pulsed once
        do_reset();
        a0 = 8'd3; b0 = 8'd2; a1 = 8'd7; b1 = 8'd1;
        req = 2'b01;
        tick();
        req = 2'b11;
        wait_done(20, d, c);
        check("t6_g0",   d, 2'b01);
        check("t6_r0",   result, 6);
        wait_done(20, d, c);
        check("t6_g1",   d, 2'b10);
        check("t6_r1",   result, 7);
        req = 2'b01;
        wait_done(20, d, c);
        check("t6_g2",   d, 2'b01);
        check("t6_r2",   result, 6);
        req = 2'b00;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
